xge_pkt_rx_drain: RTL and testbench

- Packet-side consumer sitting directly downstream of the 10GbE MAC receive interface.
- Drains the MAC RX FIFO with the pkt_rx_ren / pkt_rx_val read protocol and buffers beats in a small internal FIFO.
- Presents frames on a valid/ready stream to user logic.
- Keeps frame, error-frame and byte statistics.

---
 rtl/xge_pkt_rx_drain_if.sv | 41 ++++
 rtl/xge_pkt_rx_drain.sv | 142 ++++++++++++++
 tb/tb_xge_pkt_rx_drain.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xge_pkt_rx_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : xge_pkt_rx_drain_if
//  Description : MAC RX read-protocol signals and downstream valid/ready stream
//                bundled for xge_pkt_rx_drain.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xge_pkt_rx_drain_if;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_mod;
    logic        out_err;

    // Environment view: MAC source plus downstream sink
    modport master (
        output pkt_rx_avail, pkt_rx_val, pkt_rx_data, pkt_rx_sop,
               pkt_rx_eop, pkt_rx_mod, pkt_rx_err, out_ready,
        input  pkt_rx_ren, out_valid, out_data, out_sop, out_eop,
               out_mod, out_err
    );

    // Drain view
    modport slave (
        input  pkt_rx_avail, pkt_rx_val, pkt_rx_data, pkt_rx_sop,
               pkt_rx_eop, pkt_rx_mod, pkt_rx_err, out_ready,
        output pkt_rx_ren, out_valid, out_data, out_sop, out_eop,
               out_mod, out_err
    );
endinterface
`default_nettype wire

// File: rtl/xge_pkt_rx_drain.sv
`default_nettype none
// ============================================================================
//  Module      : xge_pkt_rx_drain
//  Description : Drains the 10GbE MAC RX FIFO into a small first-word-fall-
//                through buffer, streams beats out and keeps frame statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module xge_pkt_rx_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  wire logic             clk_156m25,
    input  wire logic             reset_156m25,
    xge_pkt_rx_drain_if.slave     rx,
    output logic [CNT_W-1:0]      stat_frames,
    output logic [CNT_W-1:0]      stat_err_frames,
    output logic [CNT_W-1:0]      stat_bytes,
    output logic                  proto_err
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = 70;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_read = 1'b1;

    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w+1)'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [CNT_W-1:0]   c_st_one  = CNT_W'(1);

    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_inflight;
    logic [0:0]         r_state;
    logic               r_in_frame;
    logic               r_proto_err;
    logic [CNT_W-1:0]   r_stat_frames;
    logic [CNT_W-1:0]   r_stat_err_frames;
    logic [CNT_W-1:0]   r_stat_bytes;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_eop_wr;
    logic               w_credit;
    logic               w_ren;
    logic [c_cnt_w:0]   w_occupancy;
    logic [3:0]         w_beat_bytes;
    logic [c_ent_w-1:0] w_wr_entry;
    logic [c_ent_w-1:0] w_head;

    // Only beats answering one of our own reads are accepted; this also drops
    // a late beat for a read issued just before reset.
    assign w_push   = rx.pkt_rx_val & r_inflight;
    assign w_empty  = (r_count == '0);
    assign w_pop    = ~w_empty & rx.out_ready;
    assign w_eop_wr = w_push & rx.pkt_rx_eop;

    assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_credit    = (w_occupancy < c_depth);
    assign w_ren       = (r_state == c_st_read) & rx.pkt_rx_avail & w_credit & ~w_eop_wr;
    assign rx.pkt_rx_ren = w_ren;

    assign w_beat_bytes = (rx.pkt_rx_eop && rx.pkt_rx_mod != 3'd0) ? {1'b0, rx.pkt_rx_mod} : 4'd8;
    assign w_wr_entry   = {rx.pkt_rx_data, rx.pkt_rx_sop, rx.pkt_rx_eop, rx.pkt_rx_mod, rx.pkt_rx_err};

    // Head entry is masked while empty so stale storage never leaks out
    assign w_head       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rx.out_valid = ~w_empty;
    assign rx.out_data  = w_head[69:6];
    assign rx.out_sop   = w_head[5];
    assign rx.out_eop   = w_head[4];
    assign rx.out_mod   = w_head[3:1];
    assign rx.out_err   = w_head[0];

    assign stat_frames     = r_stat_frames;
    assign stat_err_frames = r_stat_err_frames;
    assign stat_bytes      = r_stat_bytes;
    assign proto_err       = r_proto_err;

    always_ff @(posedge clk_156m25) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (rx.pkt_rx_avail) r_state <= c_st_read;
                c_st_read: if (w_eop_wr)        r_state <= c_st_idle;
                default:                        r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_ren;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_in_frame        <= 1'b0;
            r_proto_err       <= 1'b0;
            r_stat_frames     <= '0;
            r_stat_err_frames <= '0;
            r_stat_bytes      <= '0;
        end else if (w_push) begin
            if (rx.pkt_rx_sop == r_in_frame) begin
                r_proto_err <= 1'b1;
            end
            if (rx.pkt_rx_eop) begin
                r_in_frame        <= 1'b0;
                r_stat_frames     <= r_stat_frames + c_st_one;
                r_stat_err_frames <= r_stat_err_frames + CNT_W'(rx.pkt_rx_err);
            end else if (rx.pkt_rx_sop) begin
                r_in_frame <= 1'b1;
            end
            r_stat_bytes <= r_stat_bytes + CNT_W'(w_beat_bytes);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_xge_pkt_rx_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xge_pkt_rx_drain
//  Description : Randomised bench for xge_pkt_rx_drain with a queue-based MAC
//                source, frame/statistics model and per-cycle output compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xge_pkt_rx_drain;
    localparam int c_depth = 4;
    localparam int c_cnt_w = 32;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xge_pkt_rx_drain_if bus ();
    logic [c_cnt_w-1:0] stat_frames;
    logic [c_cnt_w-1:0] stat_err_frames;
    logic [c_cnt_w-1:0] stat_bytes;
    logic               proto_err;

    xge_pkt_rx_drain #(.FIFO_DEPTH(c_depth), .CNT_W(c_cnt_w)) dut (
        .clk_156m25      (clk),
        .reset_156m25    (rst),
        .rx              (bus.slave),
        .stat_frames     (stat_frames),
        .stat_err_frames (stat_err_frames),
        .stat_bytes      (stat_bytes),
        .proto_err       (proto_err)
    );

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     out_beats = 0;
    int     frames_left = 0;
    int     ready_mode = 1;
    bit     armed = 0;
    bit     have_pend = 0;
    beat_t  pend;
    beat_t  last_out;
    beat_t  mac_q[$];
    beat_t  exp_q[$];
    logic   ren_s = 1'b0;
    logic [31:0] m_frames = 0, m_err = 0, m_bytes = 0;
    bit     m_proto = 0, m_in_frame = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level effect of one beat being written into the buffer
    task automatic commit(input beat_t b);
        exp_q.push_back(b);
        chk("fifo_not_overflowed", exp_q.size() <= c_depth, 1'b1);
        if (b.eop) begin
            m_bytes  += (b.mod == 3'd0) ? 8 : int'(b.mod);
            m_frames += 1;
            m_err    += b.err;
        end else begin
            m_bytes  += 8;
        end
        if (b.sop && m_in_frame)  m_proto = 1;
        if (!b.sop && !m_in_frame) m_proto = 1;
        if (b.eop)      m_in_frame = 0;
        else if (b.sop) m_in_frame = 1;
    endtask

    task automatic tick();
        logic rst_e, ren_e;
        @(posedge clk);
        rst_e = rst;
        ren_e = ren_s;
        #1;
        cyc++;
        if (rst_e) begin
            exp_q.delete(); mac_q.delete();
            frames_left = 0; have_pend = 0; armed = 1;
            m_frames = 0; m_err = 0; m_bytes = 0; m_proto = 0; m_in_frame = 0;
        end else if (have_pend) begin
            commit(pend);
            have_pend = 0;
        end
        bus.pkt_rx_val = 0; bus.pkt_rx_data = '0; bus.pkt_rx_sop = 0;
        bus.pkt_rx_eop = 0; bus.pkt_rx_mod = '0; bus.pkt_rx_err = 0;
        if (rst_e) begin
            // Stray beat right after reset; must never reach the stream
            bus.pkt_rx_val = 1; bus.pkt_rx_data = 64'hDEAD_BEEF_0BAD_F00D;
            bus.pkt_rx_eop = 1; bus.pkt_rx_mod = 3'd3; bus.pkt_rx_err = 1;
        end else if (ren_e === 1'b1) begin
            chk("ren_has_frame_data", mac_q.size() != 0, 1'b1);
            if (mac_q.size() != 0) begin
                pend = mac_q.pop_front();
                have_pend = 1;
                if (pend.eop) frames_left--;
                bus.pkt_rx_val = 1; bus.pkt_rx_data = pend.data; bus.pkt_rx_sop = pend.sop;
                bus.pkt_rx_eop = pend.eop; bus.pkt_rx_mod = pend.mod; bus.pkt_rx_err = pend.err;
            end
        end
        bus.pkt_rx_avail = (frames_left > 0);
        bus.out_ready = (ready_mode == 1) ? 1'b1 :
                        (ready_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic add_frame(input int n, input int lastmod, input bit err,
                             input int sop_at, input bit nosop);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.sop  = (i == 0 && !nosop) || (i == sop_at);
            b.eop  = (i == n - 1);
            b.mod  = b.eop ? 3'(lastmod) : 3'd0;
            b.err  = b.eop ? err : 1'b0;
            mac_q.push_back(b);
        end
        frames_left++;
        bus.pkt_rx_avail = 1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mac_q.size() != 0 || have_pend || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_beats_left", mac_q.size() + exp_q.size() + int'(have_pend), 0);
    endtask

    always @(negedge clk) begin
        ren_s = bus.pkt_rx_ren;
        if (armed) begin
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("out_data", bus.out_data, exp_q[0].data);
                chk("out_flags", {bus.out_sop, bus.out_eop, bus.out_mod, bus.out_err},
                    {exp_q[0].sop, exp_q[0].eop, exp_q[0].mod, exp_q[0].err});
                if (bus.out_ready) begin
                    last_out = exp_q.pop_front();
                    out_beats++;
                end
            end
            chk("stat_frames", stat_frames, m_frames);
            chk("stat_err_frames", stat_err_frames, m_err);
            chk("stat_bytes", stat_bytes, m_bytes);
            chk("proto_err", proto_err, m_proto);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, n, gen_frames, nb, md;
        logic [31:0] gen_bytes;
        bus.pkt_rx_avail = 0; bus.pkt_rx_val = 0; bus.pkt_rx_data = '0; bus.pkt_rx_sop = 0;
        bus.pkt_rx_eop = 0; bus.pkt_rx_mod = '0; bus.pkt_rx_err = 0; bus.out_ready = 1;
        rst = 1;
        tick(); tick();
        rst = 0;
        tick(); tick();
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_ren", bus.pkt_rx_ren, 0);
        chk("reset_out_data", {bus.out_data, bus.out_sop, bus.out_eop, bus.out_mod, bus.out_err}, 0);
        chk("reset_stats", {stat_frames, stat_bytes}, 0);
        chk("reset_proto", proto_err, 0);

        // 1: 64-byte frame, latency avail -> ren -> FIFO -> out_valid
        ready_mode = 1; base = out_beats;
        add_frame(8, 0, 0, -1, 0);
        chk("t1_ren_same_cycle", bus.pkt_rx_ren, 0);
        tick(); chk("t1_ren_plus1", bus.pkt_rx_ren, 1);
        tick(); chk("t1_valid_plus2", bus.out_valid, 0);
        tick(); chk("t1_valid_plus3", bus.out_valid, 1);
        drain(200);
        chk("t1_beats", out_beats - base, 8);
        chk("t1_frames", stat_frames, 1);
        chk("t1_bytes", stat_bytes, 64);
        chk("t1_err_frames", stat_err_frames, 0);

        // 2: 61-byte errored frame
        add_frame(8, 5, 1, -1, 0);
        drain(200);
        chk("t2_last_mod_err", {last_out.eop, last_out.mod, last_out.err}, {1'b1, 3'd5, 1'b1});
        chk("t2_bytes", stat_bytes, 125);
        chk("t2_err_frames", stat_err_frames, 1);

        // 3: backpressure caps the buffer at the depth
        ready_mode = 0; base = out_beats;
        add_frame(10, 0, 0, -1, 0);
        repeat (20) tick();
        chk("t3_buffered", exp_q.size(), 4);
        chk("t3_ren_stalled", bus.pkt_rx_ren, 0);
        ready_mode = 1;
        drain(200);
        chk("t3_beats", out_beats - base, 10);
        chk("t3_bytes", stat_bytes, 205);

        // 4: back-to-back frames with avail held
        add_frame(3, 2, 0, -1, 0);
        add_frame(5, 0, 0, -1, 0);
        drain(200);
        chk("t4_frames", stat_frames, 5);
        chk("t4_bytes", stat_bytes, 263);

        // 5: sop injected mid-frame, then a clean frame
        add_frame(6, 0, 0, 3, 0);
        drain(200);
        chk("t5_proto", proto_err, 1);
        add_frame(2, 1, 0, -1, 0);
        drain(200);
        chk("t5_proto_sticky", proto_err, 1);

        // 6: reset with three beats buffered
        ready_mode = 0;
        add_frame(10, 0, 0, -1, 0);
        n = 0;
        while (exp_q.size() < 3 && n < 50) begin tick(); n++; end
        chk("t6_three_buffered", exp_q.size(), 3);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_ren", bus.pkt_rx_ren, 0);
        chk("t6_stats", {stat_frames, stat_err_frames, stat_bytes}, 0);
        chk("t6_proto", proto_err, 0);
        tick(); tick();
        chk("t6_stray_ignored", bus.out_valid, 0);
        ready_mode = 1;
        add_frame(4, 3, 0, -1, 0);
        drain(200);
        chk("t6_frames", stat_frames, 1);
        chk("t6_bytes", stat_bytes, 27);

        // Randomised traffic with random backpressure
        rst = 1; tick(); rst = 0; tick();
        ready_mode = 2; gen_frames = 0; gen_bytes = 0;
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 9);
            md = $urandom_range(0, 7);
            add_frame(nb, md, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0 && nb > 2) ? $urandom_range(1, nb - 1) : -1,
                      $urandom_range(0, 19) == 0);
            gen_frames++;
            gen_bytes += 8 * (nb - 1) + ((md == 0) ? 8 : md);
            repeat ($urandom_range(0, 6)) tick();
        end
        drain(5000);
        chk("rand_frames", stat_frames, gen_frames);
        chk("rand_bytes", stat_bytes, gen_bytes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
